ps2_rx_fifo: RTL and testbench
==============================

# ps2_rx_fifo

Parametrised PS/2 device-to-host receiver with glitch filtering, frame-error detection, a partial-frame timeout and a configurable-depth show-ahead receive FIFO. It sits between the board's PS/2 pins and the CPU I/O bus. The CPU polls `ready`, reads `data`, and pops with the active-low `rdn` strobe. Compared with the first-generation receiver, it adds full-depth FIFO use, a `level` output, error reporting and recovery from truncated frames.

## Interface
- `DEPTH_LOG2`, 3: FIFO depth is 2^DEPTH_LOG2 entries, all usable; must be ≥1.
- `FILTER_LEN`, 4: consecutive identical synchronised `ps2_clk` samples required before the filtered clock changes; must be ≥1.
- `TIMEOUT`, 5000: `clk` cycles without a filtered falling edge, while mid-frame, before the frame is aborted.
- `ERR_CNT_W`, 8: width of the saturating error counter.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `ps2_clk`  in  1  raw PS/2 clock pin; asynchronous.
- `ps2_data`  in  1  raw PS/2 data pin; asynchronous.
- `rdn`  in  1  active-low pop strobe; one entry is popped per `clk` cycle in which it is low and `ready`=1.
- `clr_err`  in  1  synchronous clear of `overflow` and `err_count`.
- `data`  out  8  head of FIFO (show-ahead); 0 when empty.
- `ready`  out  1  FIFO non-empty.
- `level`  out  DEPTH_LOG2+1  current number of FIFO entries.
- `overflow`  out  1  sticky flag: a valid frame was dropped because the FIFO was full.
- `parity_err`  out  1  one-cycle pulse on a frame with even parity.
- `frame_err`  out  1  one-cycle pulse on a bad stop bit or a timeout.
- `err_count`  out  ERR_CNT_W  count of errored frames; saturates at all-ones.

## Operation
- **Input synchronisation:** `ps2_clk` and `ps2_data` each pass through 2 flip-flops.
- **Clock filter:**
  - The filtered clock takes the synchronised value once that value has been stable for FILTER_LEN cycles.
  - A 1→0 transition of the filtered clock is a *sample*. The synchronised `ps2_data` is captured in the same cycle.
- **Frame FSM states:** IDLE, SHIFT, STOP.
  - IDLE: a sample with data=0 moves to SHIFT with bit counter 0. A sample with data=1 is ignored.
  - SHIFT: 9 samples are taken: 8 data bits LSB-first, then the parity bit. After the 9th sample the FSM moves to STOP.
  - STOP: on the next sample the frame is checked, then the FSM returns to IDLE.
  - A frame is good when stop=1 and the 8 data bits plus parity contain an odd number of ones.
- **Error handling:**
  - Parity bad → `parity_err` pulse. Stop bad → `frame_err` pulse. If both are bad, both pulse.
  - Any bad frame increments `err_count` by exactly 1 and is not pushed.
- **Timeout:**
  - In SHIFT or STOP, a cycle counter clears on every sample.
  - When it reaches TIMEOUT: `frame_err` pulses, `err_count` increments, the FSM goes to IDLE and the partial byte is discarded.
- **FIFO push:** a good frame is pushed if `level` < depth, or if a pop occurs in the same cycle. Otherwise the frame is dropped and `overflow` is set to 1.
- **FIFO pop:** a pop occurs when `rdn`=0 and `ready`=1. A pop on an empty FIFO is ignored.
- **Pointers and level:**
  - Pointers are DEPTH_LOG2 bits wide and wrap naturally.
  - `level` is +1 on a push alone, −1 on a pop alone, and unchanged on a simultaneous push and pop.
- **Overflow clear:** `overflow` clears on a pop or on `clr_err`. Set has priority when set and clear occur in the same cycle.
- **Error counter clear:** `clr_err` zeroes `err_count`. An increment in the same cycle wins, giving `err_count`=1.

## Timing
- **Reset (asynchronous):**
  - `data`=0, `ready`=0, `level`=0, `overflow`=0, `parity_err`=0, `frame_err`=0, `err_count`=0.
  - FSM=IDLE, filtered clock=1, all filter and timeout counters=0.
- **Reset mid-operation:** discards the partial frame and all FIFO contents.
- **Sample latency:** a raw `ps2_clk` fall produces the sample 2+FILTER_LEN cycles later. Glitches shorter than FILTER_LEN cycles produce no sample.
- **Push latency:** the push is registered on the clock edge after the stop-bit sample. `ready`, `level` and `data` reflect the push in the following cycle. Error pulses and the `err_count` update have the same timing.
- **Pop:** `rdn` is sampled on the `clk` rising edge. `data` shows the next entry, or 0 if empty, in the cycle after the pop. Holding `rdn` low for N cycles pops min(N, `level`) entries.
- **Outputs:** all outputs are registered or derive from registers only; there are no combinational paths from inputs to outputs.

## Test plan
1. **Single frame:** send 0x1C with odd parity and stop=1, at a 40-cycle PS/2 half-period (FILTER_LEN=4). Required: `ready`=1, `data`=0x1C, `level`=1. Pulse `rdn` for one cycle → `ready`=0, `data`=0.
2. **Errors:** send 0xF0 with wrong parity → `parity_err` pulses once, `err_count`=1, `level`=0. Then send 0x1C with stop=0 → `frame_err` pulses once, `err_count`=2.
3. **Full and overflow (DEPTH_LOG2=3):**
   - Send 9 frames 0x01..0x09 with no reads. Required: `level`=8, `overflow`=1, and reads return 0x01..0x08.
   - `overflow` clears after the first pop.
4. **Timeout and glitch rejection:**
   - Send a start bit plus 4 data bits, then idle TIMEOUT cycles → `frame_err` pulses.
   - Then send 0x5A → `data`=0x5A.
   - 2-cycle glitches on `ps2_clk` must cause no samples.
5. **Full with simultaneous pop:** with `level`=8, hold `rdn`=0 on the push cycle. Required: `level` stays 8, `overflow` stays 0, and the pointers wrap correctly across 20 frames with ordered readback.
6. **Reset and saturation:**
   - Assert `reset` mid-frame with `level`=3 → all outputs return to reset values, and the next full frame is received correctly.
   - With ERR_CNT_W=2, 5 errors → `err_count`=3. Then `clr_err` → `err_count`=0.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: input synchroniser, clock glitch filter, frame FSM
// with parity/stop/timeout checking, and a show-ahead receive FIFO for CPU polling.
module ps2_rx_fifo #(
    parameter int DEPTH_LOG2 = 3,
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 5000,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ps2_clk,
    input  logic                 ps2_data,
    input  logic                 rdn,
    input  logic                 clr_err,
    output logic [7:0]           data,
    output logic                 ready,
    output logic [DEPTH_LOG2:0]  level,
    output logic                 overflow,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic [ERR_CNT_W-1:0] err_count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;
    localparam int FW    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW    = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        STOP
    } state_t;

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          filt_clk;
    logic [FW-1:0] filt_cnt;
    logic          filt_done;
    logic          sample;

    state_t        state;
    logic [3:0]    bit_cnt;
    logic [8:0]    shreg;
    logic [TW-1:0] tmo_cnt;

    logic          chk_valid;
    logic          chk_par_bad;
    logic          chk_frm_bad;
    logic [7:0]    chk_byte;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic                  pop;
    logic                  push_req;
    logic                  push;
    logic                  err_inc;

    // Idle PS/2 lines are high, so the synchronisers reset to 1 to avoid a phantom edge.
    // NOTE: sequential state uses <= so every register updates from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    assign filt_done = (clk_sync[1] != filt_clk) && (filt_cnt == FW'(FILTER_LEN - 1));
    assign sample    = filt_done && filt_clk;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_sync[1] == filt_clk) begin
            filt_cnt <= '0;
        end else if (filt_done) begin
            filt_clk <= clk_sync[1];
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + FW'(1);
        end
    end

    // The check stage is registered so pushes and error pulses land one edge after the stop sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            tmo_cnt     <= '0;
            chk_valid   <= 1'b0;
            chk_par_bad <= 1'b0;
            chk_frm_bad <= 1'b0;
            chk_byte    <= '0;
        end else begin
            chk_valid   <= 1'b0;
            chk_par_bad <= 1'b0;
            chk_frm_bad <= 1'b0;
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (sample && !data_sync[1]) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                    end
                end
                SHIFT, STOP: begin
                    if (sample) begin
                        tmo_cnt <= '0;
                        if (state == SHIFT) begin
                            shreg   <= {data_sync[1], shreg[8:1]};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd8) begin
                                state <= STOP;
                            end
                        end else begin
                            chk_valid   <= 1'b1;
                            chk_par_bad <= ~^shreg;
                            chk_frm_bad <= ~data_sync[1];
                            chk_byte    <= shreg[7:0];
                            state       <= IDLE;
                        end
                    end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        chk_valid   <= 1'b1;
                        chk_frm_bad <= 1'b1;
                        tmo_cnt     <= '0;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ready    = (level != '0);
    assign pop      = !rdn && ready;
    assign push_req = chk_valid && !chk_par_bad && !chk_frm_bad;
    assign push     = push_req && ((level < LW'(DEPTH)) || pop);
    assign err_inc  = chk_valid && (chk_par_bad || chk_frm_bad);
    assign data     = ready ? mem[rptr] : 8'h00;

    // NOTE: the storage array has no reset; level and the pointers alone say which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= chk_byte;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr       <= '0;
            rptr       <= '0;
            level      <= '0;
            overflow   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            err_count  <= '0;
        end else begin
            parity_err <= chk_valid && chk_par_bad;
            frame_err  <= chk_valid && chk_frm_bad;

            if (push) begin
                wptr <= wptr + DEPTH_LOG2'(1);
            end
            if (pop) begin
                rptr <= rptr + DEPTH_LOG2'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase

            if (push_req && !push) begin
                overflow <= 1'b1;
            end else if (pop || clr_err) begin
                overflow <= 1'b0;
            end

            // An increment coinciding with a clear leaves exactly one error counted.
            if (err_inc) begin
                if (clr_err) begin
                    err_count <= ERR_CNT_W'(1);
                end else if (err_count != '1) begin
                    err_count <= err_count + ERR_CNT_W'(1);
                end
            end else if (clr_err) begin
                err_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: stimulus queues expected bytes and error kinds,
// a monitor compares them whenever the DUT pops data or raises an error pulse.
`timescale 1ns/1ps
module tb_ps2_rx_fifo;
    localparam int DEPTH_LOG2 = 3;
    localparam int FILTER_LEN = 4;
    localparam int TIMEOUT    = 5000;
    localparam int ERR_CNT_W  = 2;
    localparam int HALF       = 40;

    logic                 clk      = 1'b0;
    logic                 reset    = 1'b0;
    logic                 ps2_clk  = 1'b1;
    logic                 ps2_data = 1'b1;
    logic                 rdn      = 1'b1;
    logic                 clr_err  = 1'b0;
    logic [7:0]           data;
    logic                 ready;
    logic [DEPTH_LOG2:0]  level;
    logic                 overflow;
    logic                 parity_err;
    logic                 frame_err;
    logic [ERR_CNT_W-1:0] err_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_data_q [$];
    logic [1:0] exp_err_q  [$];

    always #5 clk = ~clk;

    ps2_rx_fifo #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .FILTER_LEN(FILTER_LEN),
        .TIMEOUT   (TIMEOUT),
        .ERR_CNT_W (ERR_CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rdn       (rdn),
        .clr_err   (clr_err),
        .data      (data),
        .ready     (ready),
        .level     (level),
        .overflow  (overflow),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .err_count (err_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Device drives data while the clock is high; pop_on_push lowers rdn on the push edge of the last bit.
    task automatic send_bits(input logic [10:0] bits, input int nbits, input bit pop_on_push);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            wait_cyc(HALF);
            ps2_clk = 1'b0;
            if (pop_on_push && i == nbits - 1) begin
                wait_cyc(2 + FILTER_LEN);
                rdn = 1'b0;
                wait_cyc(1);
                rdn = 1'b1;
                wait_cyc(HALF - 3 - FILTER_LEN);
            end else begin
                wait_cyc(HALF);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                              input bit accept, input bit pop_on_push);
        logic       p;
        logic [10:0] bits;
        p    = (~^d) ^ bad_par;
        bits = {~bad_stop, p, d, 1'b0};
        if (bad_par || bad_stop) begin
            exp_err_q.push_back({bad_par, bad_stop});
        end else if (accept) begin
            exp_data_q.push_back(d);
        end
        send_bits(bits, 11, pop_on_push);
        wait_cyc(HALF);
    endtask

    task automatic read_n(input int n);
        rdn = 1'b0;
        wait_cyc(n);
        rdn = 1'b1;
        wait_cyc(1);
    endtask

    // Monitor: samples just after the falling edge, i.e. the values the next rising edge will see.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (reset && !rdn && ready) begin
                if (exp_data_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pop: got 0x%0h, expected no entry", data);
                end else begin
                    check("pop_data", data, exp_data_q.pop_front());
                end
            end
            if (parity_err || frame_err) begin
                if (exp_err_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_err: got par=%0b frm=%0b, expected none",
                             parity_err, frame_err);
                end else begin
                    check("err_kind", {parity_err, frame_err}, exp_err_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wait_cyc(3);
        check("rst_data", data, 0);
        check("rst_ready", ready, 0);
        check("rst_level", level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_err_count", err_count, 0);
        reset = 1'b1;
        wait_cyc(5);

        // Single frame
        send_frame(8'h1C, 0, 0, 1, 0);
        check("t1_ready", ready, 1);
        check("t1_data", data, 8'h1C);
        check("t1_level", level, 1);
        read_n(1);
        check("t1_ready_after_pop", ready, 0);
        check("t1_data_after_pop", data, 0);

        // Parity error, then stop-bit error
        send_frame(8'hF0, 1, 0, 0, 0);
        check("t2_err_count_par", err_count, 1);
        check("t2_level_par", level, 0);
        send_frame(8'h1C, 0, 1, 0, 0);
        check("t2_err_count_stop", err_count, 2);
        check("t2_level_stop", level, 0);

        // Fill to full, ninth frame overflows
        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i), 0, 0, i <= 8, 0);
        end
        check("t3_level_full", level, 8);
        check("t3_overflow_set", overflow, 1);
        read_n(1);
        check("t3_overflow_clr", overflow, 0);
        check("t3_level_7", level, 7);
        read_n(7);
        check("t3_level_empty", level, 0);

        // Truncated frame times out
        exp_err_q.push_back(2'b01);
        send_bits({1'b1, 1'b1, 8'h0F, 1'b0}, 5, 0);
        wait_cyc(TIMEOUT + 200);
        check("t4_err_count_tmo", err_count, 3);
        check("t4_level_tmo", level, 0);
        send_frame(8'h5A, 0, 0, 1, 0);
        check("t4_data_5a", data, 8'h5A);
        read_n(1);

        // Short glitches with data low must not start a frame
        ps2_data = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ps2_clk = 1'b0;
            wait_cyc(2);
            ps2_clk = 1'b1;
            wait_cyc(20);
        end
        ps2_data = 1'b1;
        wait_cyc(HALF);
        send_frame(8'h3C, 0, 0, 1, 0);
        check("t4_glitch_level", level, 1);
        check("t4_glitch_data", data, 8'h3C);
        read_n(1);

        // Full FIFO with a pop on every push cycle, wrapping pointers
        for (int i = 0; i < 8; i++) begin
            send_frame(8'(8'h10 + i), 0, 0, 1, 0);
        end
        check("t5_level_full", level, 8);
        for (int i = 0; i < 20; i++) begin
            send_frame(8'(8'h20 + i), 0, 0, 1, 1);
            check("t5_level_hold", level, 8);
            check("t5_no_overflow", overflow, 0);
        end
        read_n(8);
        check("t5_level_empty", level, 0);

        // Reset mid-frame with three entries queued
        send_frame(8'h41, 0, 0, 1, 0);
        send_frame(8'h42, 0, 0, 1, 0);
        send_frame(8'h43, 0, 0, 1, 0);
        check("t6_level_3", level, 3);
        send_bits({1'b1, 1'b0, 8'h99, 1'b0}, 6, 0);
        reset = 1'b0;
        exp_data_q.delete();
        wait_cyc(2);
        check("t6_rst_data", data, 0);
        check("t6_rst_ready", ready, 0);
        check("t6_rst_level", level, 0);
        check("t6_rst_overflow", overflow, 0);
        check("t6_rst_pulses", {parity_err, frame_err}, 0);
        check("t6_rst_err_count", err_count, 0);
        wait_cyc(2);
        reset = 1'b1;
        wait_cyc(HALF);
        send_frame(8'hA5, 0, 0, 1, 0);
        check("t6_level_after_rst", level, 1);
        check("t6_data_after_rst", data, 8'hA5);
        read_n(1);

        // Saturating error counter and clear
        send_frame(8'h11, 1, 0, 0, 0);
        send_frame(8'h22, 0, 1, 0, 0);
        send_frame(8'h33, 1, 1, 0, 0);
        send_frame(8'h44, 1, 0, 0, 0);
        send_frame(8'h55, 0, 1, 0, 0);
        check("t6_err_saturated", err_count, 3);
        clr_err = 1'b1;
        wait_cyc(1);
        clr_err = 1'b0;
        wait_cyc(1);
        check("t6_err_cleared", err_count, 0);
        check("t6_level_final", level, 0);

        wait_cyc(10);
        check("data_queue_drained", exp_data_q.size(), 0);
        check("err_queue_drained", exp_err_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
